// File: rtl/paddle_bank.sv
// paddle_bank: bank of independent game paddles updated once per 60 Hz frame tick.
// Each paddle has an IDLE/UP/DOWN FSM; y is clamped to [Y_MIN, Y_MAX-PADDLE_LEN].
// Optional feature macro: PADDLE_BANK_ACCEL_EN enables speed ramping on held direction;
// without it a paddle always moves 1 pixel per tick while UP/DOWN.
module paddle_bank #(
  parameter int unsigned N_PADDLES  = 2,
  parameter int unsigned PADDLE_LEN = 20,
  parameter int unsigned Y_MIN      = 31,
  parameter int unsigned Y_MAX      = 119,
  parameter int unsigned Y_RESET    = 75,
  parameter int unsigned MAX_SPEED  = 4,
  parameter int unsigned RAMP_TICKS = 8
) (
  input  logic                     sixtyhz_clk,
  input  logic                     resetn,
  input  logic                     freeze,
  input  logic                     recentre,
  input  logic [N_PADDLES-1:0]     inc,
  input  logic [N_PADDLES-1:0]     dec,
  output logic [7*N_PADDLES-1:0]   paddle_y,
  output logic [N_PADDLES-1:0]     moving,
  output logic [N_PADDLES-1:0]     at_top,
  output logic [N_PADDLES-1:0]     at_bottom
);

  localparam int unsigned Y_BOT   = Y_MAX - PADDLE_LEN;
  localparam logic [7:0]  Y_MIN8  = 8'(Y_MIN);
  localparam logic [7:0]  Y_BOT8  = 8'(Y_BOT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  // Reject parameter sets that would overflow the 3-bit speed or 7-bit position.
  if (MAX_SPEED == 0 || MAX_SPEED > 7 || RAMP_TICKS == 0 || Y_MAX > 127 ||
      PADDLE_LEN > Y_MAX || Y_MIN > Y_BOT) begin : g_bad_params
    $error("paddle_bank: illegal parameter set");
  end

`ifdef PADDLE_BANK_ACCEL_EN
  localparam int unsigned RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
`endif

  for (genvar g = 0; g < N_PADDLES; g++) begin : g_pad
    logic [1:0] state_q, state_d;
    logic [1:0] req_state;
    logic [2:0] speed_d;
    logic [6:0] y_q, y_d;
    logic [7:0] y_ext, y_sum;
    logic       moving_q, moving_d;
    logic       at_top_q, at_top_d;
    logic       at_bottom_q, at_bottom_d;
`ifdef PADDLE_BANK_ACCEL_EN
    logic [2:0]        speed_q;
    logic [RAMP_W-1:0] ramp_q, ramp_d;
`endif

    // Next-state: direction decode, speed ramp and clamped position update.
    always_comb begin
      state_d     = state_q;
      speed_d     = 3'd0;
      y_d         = y_q;
      y_ext       = {1'b0, y_q};
      y_sum       = 8'd0;
`ifdef PADDLE_BANK_ACCEL_EN
      speed_d     = speed_q;
      ramp_d      = ramp_q;
`endif
      if (inc[g] && !dec[g])      req_state = ST_DOWN;
      else if (dec[g] && !inc[g]) req_state = ST_UP;
      else                        req_state = ST_IDLE;

      if (recentre) begin
        state_d = ST_IDLE;
        speed_d = 3'd0;
        y_d     = 7'(Y_RESET);
`ifdef PADDLE_BANK_ACCEL_EN
        ramp_d  = '0;
`endif
      end else if (!freeze) begin
        state_d = req_state;
        if (req_state == ST_IDLE) begin
          speed_d = 3'd0;
        end else if (req_state != state_q) begin
          speed_d = 3'd1;
`ifdef PADDLE_BANK_ACCEL_EN
          ramp_d  = '0;
`endif
        end else begin
`ifdef PADDLE_BANK_ACCEL_EN
          if (ramp_q == RAMP_W'(RAMP_TICKS - 1)) begin
            ramp_d = '0;
            if (speed_q < 3'(MAX_SPEED)) speed_d = speed_q + 3'd1;
          end else begin
            ramp_d = ramp_q + RAMP_W'(1);
          end
`else
          speed_d = 3'd1;
`endif
        end

        // Movement uses this tick's updated speed so motion starts immediately.
        if (req_state == ST_DOWN) begin
          y_sum = y_ext + {5'd0, speed_d};
          y_d   = (y_sum >= Y_BOT8) ? 7'(Y_BOT) : y_sum[6:0];
        end else if (req_state == ST_UP) begin
          if (y_ext >= Y_MIN8 + {5'd0, speed_d}) begin
            y_sum = y_ext - {5'd0, speed_d};
            y_d   = y_sum[6:0];
          end else begin
            y_d   = 7'(Y_MIN);
          end
        end
      end

      moving_d    = (y_d != y_q);
      at_top_d    = ({1'b0, y_d} == Y_MIN8);
      at_bottom_d = ({1'b0, y_d} == Y_BOT8);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sixtyhz_clk) begin
      if (!resetn) begin
        state_q     <= ST_IDLE;
        y_q         <= 7'(Y_RESET);
        moving_q    <= 1'b0;
        at_top_q    <= (Y_RESET == Y_MIN);
        at_bottom_q <= (Y_RESET == Y_BOT);
`ifdef PADDLE_BANK_ACCEL_EN
        speed_q     <= 3'd0;
        ramp_q      <= '0;
`endif
      end else begin
        state_q     <= state_d;
        y_q         <= y_d;
        moving_q    <= moving_d;
        at_top_q    <= at_top_d;
        at_bottom_q <= at_bottom_d;
`ifdef PADDLE_BANK_ACCEL_EN
        speed_q     <= speed_d;
        ramp_q      <= ramp_d;
`endif
      end
    end

    assign paddle_y[7*g +: 7] = y_q;
    assign moving[g]          = moving_q;
    assign at_top[g]          = at_top_q;
    assign at_bottom[g]       = at_bottom_q;
  end

endmodule

// File: tb/tb_paddle_bank.sv
// tb_paddle_bank: directed scenarios plus randomized traffic checked every tick
// against a run-length based reference model of paddle motion.
module tb_paddle_bank;

  localparam int NP     = 2;
  localparam int YMIN   = 31;
  localparam int YBOT   = 99;
  localparam int YRST   = 75;
  localparam int MAXSPD = 4;
  localparam int RAMP   = 8;

  logic          sixtyhz_clk = 1'b0;
  logic          resetn, freeze, recentre;
  logic [NP-1:0] inc, dec;
  logic [7*NP-1:0] paddle_y;
  logic [NP-1:0] moving, at_top, at_bottom;

  int tests = 0;
  int fails = 0;

  // Reference: position, current request direction and length of the current run.
  int m_y[NP];
  int m_dir[NP];
  int m_run[NP];
  int m_mov[NP];

  paddle_bank dut (
    .sixtyhz_clk(sixtyhz_clk),
    .resetn     (resetn),
    .freeze     (freeze),
    .recentre   (recentre),
    .inc        (inc),
    .dec        (dec),
    .paddle_y   (paddle_y),
    .moving     (moving),
    .at_top     (at_top),
    .at_bottom  (at_bottom)
  );

  always #5 sixtyhz_clk = ~sixtyhz_clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Speed is a function of how many consecutive ticks one direction has been held.
  function automatic int model_speed(input int run);
`ifdef PADDLE_BANK_ACCEL_EN
    int s;
    s = 1 + (run - 1) / RAMP;
    return (s > MAXSPD) ? MAXSPD : s;
`else
    return (run > 0) ? 1 : 0;
`endif
  endfunction

  task automatic step_model();
    int r, ny;
    for (int i = 0; i < NP; i++) begin
      if (!resetn) begin
        m_y[i] = YRST; m_dir[i] = 0; m_run[i] = 0; m_mov[i] = 0;
      end else if (recentre) begin
        m_mov[i] = (m_y[i] != YRST);
        m_y[i] = YRST; m_dir[i] = 0; m_run[i] = 0;
      end else if (freeze) begin
        m_mov[i] = 0;
      end else begin
        r = (inc[i] && !dec[i]) ? 2 : (dec[i] && !inc[i]) ? 1 : 0;
        if (r == 0)             m_run[i] = 0;
        else if (r == m_dir[i]) m_run[i] = m_run[i] + 1;
        else                    m_run[i] = 1;
        m_dir[i] = r;
        ny = m_y[i];
        if (r == 2) ny = (m_y[i] + model_speed(m_run[i]) > YBOT) ? YBOT : m_y[i] + model_speed(m_run[i]);
        if (r == 1) ny = (m_y[i] - model_speed(m_run[i]) < YMIN) ? YMIN : m_y[i] - model_speed(m_run[i]);
        m_mov[i] = (ny != m_y[i]);
        m_y[i] = ny;
      end
    end
  endtask

  // One frame tick: advance the model at the edge, compare outputs just after it.
  task automatic tick();
    @(posedge sixtyhz_clk);
    step_model();
    #1;
    for (int i = 0; i < NP; i++) begin
      check_eq($sformatf("y%0d", i), int'(paddle_y[7*i +: 7]), m_y[i]);
      check_eq($sformatf("moving%0d", i), int'(moving[i]), m_mov[i]);
      check_eq($sformatf("at_top%0d", i), int'(at_top[i]), int'(m_y[i] == YMIN));
      check_eq($sformatf("at_bottom%0d", i), int'(at_bottom[i]), int'(m_y[i] == YBOT));
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drive(input logic rn, input logic fr, input logic rc,
                       input logic [NP-1:0] in_i, input logic [NP-1:0] de_i);
    resetn = rn; freeze = fr; recentre = rc; inc = in_i; dec = de_i;
  endtask

  initial begin
    int hold_inc, hold_dec;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    ticks(2);

    // Idle after reset: everything parked at the reset row.
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    ticks(5);
    check_eq("idle_y0", int'(paddle_y[6:0]), YRST);
    check_eq("idle_y1", int'(paddle_y[13:7]), YRST);
    check_eq("idle_moving", int'(moving), 0);

    // Hold down on paddle 0 into the bottom clamp.
    drive(1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
    ticks(20);
`ifdef PADDLE_BANK_ACCEL_EN
    check_eq("down20_y0", int'(paddle_y[6:0]), YBOT);
    check_eq("down20_bottom", int'(at_bottom[0]), 1);
    check_eq("down20_moving", int'(moving[0]), 0);
`else
    check_eq("down20_y0", int'(paddle_y[6:0]), YRST + 20);
`endif

    // Conflicting requests on paddle 1 leave it still; paddle 0 unaffected.
    drive(1'b1, 1'b0, 1'b1, '0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'b10, 2'b10);
    ticks(3);
    check_eq("both_y1", int'(paddle_y[13:7]), YRST);
    check_eq("both_y0", int'(paddle_y[6:0]), YRST);

    // Hold up, freeze mid-ramp, then resume without restarting the ramp.
    drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    ticks(12);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b01);
    ticks(3);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    ticks(2);

    // Recentre beats freeze; next request restarts at speed 1.
    drive(1'b1, 1'b1, 1'b1, 2'b01, 2'b00);
    tick();
    check_eq("recentre_y0", int'(paddle_y[6:0]), YRST);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    tick();
    check_eq("after_recentre_y0", int'(paddle_y[6:0]), YRST - 1);

    // Long hold up into the top clamp.
    drive(1'b1, 1'b0, 1'b1, '0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    ticks(50);
    check_eq("up50_y0", int'(paddle_y[6:0]), YMIN);
    check_eq("up50_top", int'(at_top[0]), 1);

    // Reset mid-ramp discards speed.
    drive(1'b1, 1'b0, 1'b1, '0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
    ticks(12);
    drive(1'b0, 1'b1, 1'b1, 2'b01, 2'b00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
    tick();
    check_eq("post_reset_y0", int'(paddle_y[6:0]), YRST + 1);

    // Random traffic: sticky directions so ramps build, occasional control pulses.
    hold_inc = 0; hold_dec = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) hold_inc = int'($urandom_range(3));
      if ($urandom_range(7) == 0) hold_dec = int'($urandom_range(3));
      drive(($urandom_range(199) != 0), ($urandom_range(9) == 0), ($urandom_range(79) == 0),
            NP'(hold_inc), NP'(hold_dec));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/paddle_bank.md
PADDLE_BANK -- requirements
Module: paddle_bank

Interface
REQ-001 The block SHALL expose parameter N_PADDLES, default 2, number of independent paddles.
REQ-002 The block SHALL expose parameter PADDLE_LEN, default 20, paddle length in pixels.
REQ-003 The block SHALL expose parameter Y_MIN, default 31, smallest legal paddle top y.
REQ-004 The block SHALL expose parameter Y_MAX, default 119, bottom playfield row; largest legal top y = Y_MAX - PADDLE_LEN (default 99).
REQ-005 The block SHALL expose parameter Y_RESET, default 75, top y applied on reset or recentre.
REQ-006 The block SHALL expose parameter MAX_SPEED, default 4, maximum pixels moved per tick.
REQ-007 The block SHALL expose parameter RAMP_TICKS, default 8, consecutive same-direction ticks per speed increment.
REQ-008 Port: sixtyhz_clk  in  1  frame tick clock; all logic on its rising edge.
REQ-009 Port: resetn  in  1  reset, synchronous, active-low.
REQ-010 Port: freeze  in  1  high = hold all paddle state (draw/erase phases).
REQ-011 Port: recentre  in  1  high = return all paddles to Y_RESET.
REQ-012 Port: inc  in  N_PADDLES  bit i high = move paddle i down (y increasing).
REQ-013 Port: dec  in  N_PADDLES  bit i high = move paddle i up (y decreasing).
REQ-014 Port: paddle_y  out  7*N_PADDLES  packed top y; paddle i at bits [7i+6:7i].
REQ-015 Port: moving  out  N_PADDLES  bit i high = paddle i position changed on the last tick.
REQ-016 Port: at_top  out  N_PADDLES  bit i high = paddle i y equals Y_MIN.
REQ-017 Port: at_bottom  out  N_PADDLES  bit i high = paddle i y equals Y_MAX - PADDLE_LEN.

Function
REQ-018 Each paddle SHALL run an independent FSM with states IDLE, UP, DOWN, and a 3-bit speed register plus a ramp counter.
REQ-019 Direction request SHALL resolve per tick: inc only -> DOWN, dec only -> UP, both or neither -> IDLE.
REQ-020 Entering UP or DOWN from any other state SHALL set speed to 1 and clear the ramp counter; entering IDLE SHALL set speed 0.
REQ-021 Remaining in UP or DOWN SHALL increment the ramp counter; when it reaches RAMP_TICKS-1 it SHALL clear and speed SHALL increment, saturating at MAX_SPEED.
REQ-022 Position update SHALL use the speed value in effect after the REQ-020/021 update of the same tick, so movement occurs on the first request tick.
REQ-023 Arithmetic SHALL be 8-bit unsigned; DOWN: y <= min(y+speed, Y_MAX-PADDLE_LEN); UP: y <= max(y-speed, Y_MIN); no wrap-around under any parameter-legal value.
REQ-024 A paddle held against a limit SHALL keep its FSM state and ramp speed but SHALL not change y; moving bit SHALL be 0.
REQ-025 freeze high SHALL hold y, FSM state, speed and ramp counter unchanged; moving SHALL be 0 on that tick.
REQ-026 recentre high SHALL set all y to Y_RESET, all FSMs to IDLE, speed 0, ramp counters 0, and SHALL take priority over freeze and inc/dec.
REQ-027 All outputs SHALL be registered; paddle_y, at_top, at_bottom SHALL reflect the new position one tick after the request edge.
REQ-028 moving bit i SHALL be 1 exactly when paddle i's y changed value at that edge.

Reset
REQ-029 resetn low at a rising edge SHALL set every y to Y_RESET, FSMs to IDLE, speed 0, ramp counters 0, moving 0, at_top 0, at_bottom 0 (default parameters), overriding recentre, freeze and inputs.
REQ-030 Reset asserted mid-ramp SHALL discard accumulated speed; first movement after release starts at speed 1.

Configuration
REQ-031 Macro PADDLE_BANK_ACCEL_EN defined SHALL enable speed ramping per REQ-020/021.
REQ-032 Without PADDLE_BANK_ACCEL_EN, speed SHALL be fixed at 1 while in UP/DOWN, ramp counter SHALL not exist, and MAX_SPEED/RAMP_TICKS SHALL be ignored.

Verification
REQ-033 Reset, then no input 5 ticks -> all paddle_y = 75, moving = 0, at_top = at_bottom = 0.
REQ-034 ACCEL_EN, inc[0] held 20 ticks from y=75 -> speeds 1 x8, 2 x8, 3 x4 -> y=75+8+16+12=111 clamped to 99 once reached, at_bottom[0]=1, moving[0]=0 after clamp.
REQ-035 inc[1] and dec[1] both high 3 ticks -> paddle 1 stays 75, moving[1]=0; paddle 0 unaffected by paddle 1 inputs.
REQ-036 dec[0] held 12 ticks then freeze high 3 ticks with dec held, then freeze low -> y holds during freeze; speed continues at 2 after release (no restart).
REQ-037 Paddle 0 at y=40 moving DOWN at speed 3, recentre and freeze both high one tick -> y=75, next dec request moves at speed 1.
REQ-038 ACCEL_EN undefined, dec[0] held 50 ticks from 75 -> y decreases 1 per tick, reaches 31 after 44 ticks, at_top[0]=1, stays 31.
